usb_timer_sched: RTL and testbench



---
 rtl/usb_timer_sched_if.sv | 24 ++
 rtl/usb_timer_sched.sv | 119 +++++++++++
 tb/tb_usb_timer_sched.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_timer_sched_if.sv
// Requester-side bundle for the shared USB interval timer: per-requester request/terminal count in,
// grant/completion/status out.
interface usb_timer_sched_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 16
);
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len;
   logic               tick;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic               busy;
   logic [CW-1:0]      cnt;

   modport master (
      output req, len, tick,
      input  gnt, done, busy, cnt
   );

   modport slave (
      input  req, len, tick,
      output gnt, done, busy, cnt
   );
endinterface

// File: rtl/usb_timer_sched.sv
// Round-robin owner of one interval counter shared by NREQ USB timers; grants, counts ticks to the
// winner's terminal count, pulses done, then holds a fixed guard gap before re-arbitrating.
module usb_timer_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 16,
   parameter int unsigned GAP  = 2
) (
   input logic              clk,
   input logic              rst_n,
   usb_timer_sched_if.slave bus
);
   localparam int unsigned   PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CW-1:0] GapLast = CW'((GAP == 0) ? 0 : GAP - 1);
   localparam logic [PW-1:0] LastIdx = PW'(NREQ - 1);

   typedef enum logic [1:0] {StIdle, StCount, StGuard} state_e;

   state_e          state_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   win_q;
   logic [CW-1:0]   tc_q;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] done_q;
   logic            busy_q;

   logic [CW-1:0]   len_arr [NREQ];
   logic            found;
   logic [PW-1:0]   pick;
   logic [PW-1:0]   sel;
   logic [CW-1:0]   pick_len;
   logic [PW-1:0]   ptr_next;
   logic            win_req;
   int unsigned     idx;

   for (genvar g = 0; g < NREQ; g++) begin : g_len
      assign len_arr[g] = bus.len[g*CW +: CW];
   end

   // Scan from ptr upward with wrap; first requester found wins.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      sel      = '0;
      pick_len = '0;
      idx      = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         sel = PW'(idx);
         if (!found && bus.req[sel]) begin
            found    = 1'b1;
            pick     = sel;
            pick_len = len_arr[sel];
         end
      end
   end

   assign ptr_next = (win_q == LastIdx) ? '0 : win_q + PW'(1);
   assign win_req  = bus.req[win_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         win_q   <= '0;
         tc_q    <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= '0;
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (found) begin
                  state_q <= StCount;
                  win_q   <= pick;
                  tc_q    <= pick_len;
                  gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                  busy_q  <= 1'b1;
               end else begin
                  gnt_q  <= '0;
                  busy_q <= 1'b0;
               end
            end
            StCount: begin
               // Abort (req dropped) outranks a coincident terminal tick: no done in that case.
               if (!win_req || (bus.tick && cnt_q == tc_q)) begin
                  gnt_q   <= '0;
                  cnt_q   <= '0;
                  ptr_q   <= ptr_next;
                  done_q  <= win_req ? gnt_q : '0;
                  state_q <= (GAP == 0) ? StIdle : StGuard;
                  busy_q  <= (GAP != 0) || win_req;
               end else if (bus.tick) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StGuard: begin
               if (cnt_q == GapLast) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
   assign bus.cnt  = cnt_q;
endmodule

// File: tb/tb_usb_timer_sched.sv
// Bench for usb_timer_sched: a GAP=2 and a GAP=0 instance share stimulus and are both checked
// every cycle against an interval-level model, plus literal checks of the directed scenarios.
module tb_usb_timer_sched;
   localparam int N = 4;
   localparam int W = 16;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req   = '0;
   logic [N*W-1:0] len = '0;
   logic         tick  = 1'b0;

   int total = 0;
   int bad   = 0;

   usb_timer_sched_if #(.NREQ(N), .CW(W)) if_a ();
   usb_timer_sched_if #(.NREQ(N), .CW(W)) if_b ();

   assign if_a.req  = req;
   assign if_a.len  = len;
   assign if_a.tick = tick;
   assign if_b.req  = req;
   assign if_b.len  = len;
   assign if_b.tick = tick;

   usb_timer_sched #(.NREQ(N), .CW(W), .GAP(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   usb_timer_sched #(.NREQ(N), .CW(W), .GAP(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 timing an interval, 2 guard gap.
   int           phase [2];
   int           win   [2];
   int           tcm   [2];
   int           ticks [2];
   int           gcnt  [2];
   int           ptr   [2];
   logic [N-1:0] done_m [2];
   int           gapv  [2] = '{2, 0};

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         phase[k] = 0; win[k] = 0; tcm[k] = 0; ticks[k] = 0;
         gcnt[k] = 0; ptr[k] = 0; done_m[k] = '0;
      end
   endtask

   task automatic close_interval(int k, bit fired);
      logic [N-1:0] one;
      one       = 1;
      done_m[k] = fired ? (one << win[k]) : '0;
      ptr[k]    = (win[k] + 1) % N;
      phase[k]  = (gapv[k] > 0) ? 2 : 0;
      gcnt[k]   = 0;
   endtask

   task automatic model_step(int k);
      bit hit;
      int j;
      done_m[k] = '0;
      case (phase[k])
         0: if (req != 0) begin
            hit = 0;
            for (int i = 0; i < N; i++) begin
               j = (ptr[k] + i) % N;
               if (!hit && req[j]) begin hit = 1; win[k] = j; end
            end
            tcm[k]   = int'(len[win[k]*W +: W]);
            ticks[k] = 0;
            phase[k] = 1;
         end
         1: begin
            if (!req[win[k]]) close_interval(k, 0);
            else if (tick) begin
               if (ticks[k] == tcm[k]) close_interval(k, 1);
               else ticks[k]++;
            end
         end
         default: begin
            if (gcnt[k] == gapv[k] - 1) phase[k] = 0;
            else gcnt[k]++;
         end
      endcase
   endtask

   task automatic cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h want %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
      cmp(name, 0, act, exp);
   endtask

   task automatic check(int k);
      logic [N-1:0] one, eg, ag, ad;
      logic [W-1:0] ec, ac;
      logic         eb, ab;
      one = 1;
      eg  = (phase[k] == 1) ? (one << win[k]) : '0;
      ec  = (phase[k] == 1) ? W'(ticks[k]) : (phase[k] == 2) ? W'(gcnt[k]) : '0;
      eb  = (phase[k] != 0) || (done_m[k] != 0);
      if (k == 0) begin ag = if_a.gnt; ad = if_a.done; ab = if_a.busy; ac = if_a.cnt; end
      else        begin ag = if_b.gnt; ad = if_b.done; ab = if_b.busy; ac = if_b.cnt; end
      cmp("gnt", k, 32'(ag), 32'(eg));
      cmp("done", k, 32'(ad), 32'(done_m[k]));
      cmp("busy", k, 32'(ab), 32'(eb));
      cmp("cnt", k, 32'(ac), 32'(ec));
   endtask

   // One clock: model advances on the edge (unless held in reset), outputs checked at negedge.
   task automatic cyc();
      @(posedge clk);
      if (rst_n) begin model_step(0); model_step(1); end
      @(negedge clk);
      check(0);
      check(1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] prev;
      logic [N-1:0] seq [$];
      logic [N-1:0] one;
      bit hit;
      one = 1;
      model_reset();
      cyc();
      cyc();
      lit("rst.gnt", 32'(if_a.gnt), 0);
      lit("rst.done", 32'(if_a.done), 0);
      lit("rst.busy", 32'(if_a.busy), 0);
      lit("rst.cnt", 32'(if_a.cnt), 0);
      rst_n = 1'b1;

      // Single request, len0=3, tick tied high
      req = 4'b0001; len[0 +: W] = 16'd3; tick = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         lit("s1.gnt", 32'(if_a.gnt), (c <= 4) ? 1 : 0);
         if (c <= 4) lit("s1.cnt", 32'(if_a.cnt), 32'(c - 1));
         lit("s1.done", 32'(if_a.done), (c == 5) ? 1 : 0);
         if (c <= 6) lit("s1.busy_hi", 32'(if_a.busy), 1);
         if (c == 8) lit("s1.busy_lo", 32'(if_a.busy), 0);
         if (c == 5) req = '0;
      end
      repeat (4) cyc();

      // Round robin on the GAP=0 instance
      do_reset();
      len = '0; req = 4'b1111; tick = 1'b1;
      prev = '0;
      for (int c = 1; c <= 9; c++) begin
         cyc();
         if (if_b.gnt != 0) begin
            lit("s2.sep", 32'(prev), 0);
            seq.push_back(if_b.gnt);
         end
         prev = if_b.gnt;
      end
      lit("s2.count", 32'(seq.size()), 5);
      for (int i = 0; i < 5 && i < seq.size(); i++)
         lit("s2.order", 32'(seq[i]), 32'(one << (i % N)));
      req = '0;
      repeat (6) cyc();

      // Tick every third cycle, len2=1
      len = '0; len[2*W +: W] = 16'd1; req = 4'b0100; tick = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         cyc();
         lit("s3.gnt", 32'(if_a.gnt), (t <= 5) ? 32'h4 : 0);
         lit("s3.done", 32'(if_a.done), (t == 6) ? 32'h4 : 0);
         if (if_a.gnt != 0) lit("s3.cnt_le1", (if_a.cnt <= 1) ? 1 : 0, 1);
         tick = (t % 3 == 2);
         if (t == 6) req = '0;
      end
      tick = 1'b1;
      repeat (4) cyc();

      // Abort: move ptr to 1 first, then abort requester 1 at cnt=4
      do_reset();
      len = '0; req = 4'b0001;
      cyc(); cyc();
      req = '0;
      repeat (4) cyc();
      len[1*W +: W] = 16'd10; req = 4'b0111;
      hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
         cyc();
         if (if_a.gnt == 4'b0010 && if_a.cnt == 4) begin req = 4'b0101; hit = 1; end
      end
      lit("s4.reach", 32'(hit), 1);
      cyc();
      lit("s4.gnt_off", 32'(if_a.gnt), 0);
      lit("s4.no_done", 32'(if_a.done), 0);
      hit = 0;
      for (int c = 0; c < 8 && !hit; c++) begin
         cyc();
         lit("s4.quiet", 32'(if_a.done), 0);
         if (if_a.gnt != 0) begin lit("s4.next", 32'(if_a.gnt), 32'h4); hit = 1; end
      end
      lit("s4.regrant", 32'(hit), 1);
      req = '0;
      repeat (16) cyc();

      // Abort coincident with terminal tick on requester 3
      do_reset();
      len = '0; len[3*W +: W] = 16'd2; req = 4'b1000; tick = 1'b1;
      hit = 0;
      for (int c = 0; c < 10 && !hit; c++) begin
         cyc();
         if (if_a.gnt == 4'b1000 && if_a.cnt == 2) begin req = '0; hit = 1; end
      end
      lit("s5.reach", 32'(hit), 1);
      cyc();
      lit("s5.gnt_off", 32'(if_a.gnt), 0);
      lit("s5.no_done", 32'(if_a.done), 0);
      cyc();
      lit("s5.no_done2", 32'(if_a.done), 0);
      req = 4'b1001;
      hit = 0;
      for (int c = 0; c < 8 && !hit; c++) begin
         cyc();
         if (if_a.gnt != 0) begin lit("s5.ptr", 32'(if_a.gnt), 1); hit = 1; end
      end
      lit("s5.regrant", 32'(hit), 1);
      req = '0;
      repeat (6) cyc();

      // Asynchronous reset in the middle of an interval
      len = '0; len[0 +: W] = 16'd20; req = 4'b0001; tick = 1'b1;
      hit = 0;
      for (int c = 0; c < 15 && !hit; c++) begin
         cyc();
         if (if_a.gnt == 4'b0001 && if_a.cnt == 5) hit = 1;
      end
      lit("s6.reach", 32'(hit), 1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      lit("s6.gnt", 32'(if_a.gnt), 0);
      lit("s6.done", 32'(if_a.done), 0);
      lit("s6.busy", 32'(if_a.busy), 0);
      lit("s6.cnt", 32'(if_a.cnt), 0);
      check(0);
      check(1);
      req = 4'b1010;
      cyc();
      rst_n = 1'b1;
      hit = 0;
      for (int c = 0; c < 6 && !hit; c++) begin
         cyc();
         if (if_a.gnt != 0) begin lit("s6.first", 32'(if_a.gnt), 32'h2); hit = 1; end
      end
      lit("s6.regrant", 32'(hit), 1);
      req = '0;
      repeat (30) cyc();

      // Random traffic
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 4) == 0) req[$urandom_range(0, N-1)] ^= 1'b1;
         if ($urandom_range(0, 5) == 0) len[$urandom_range(0, N-1)*W +: W] = W'($urandom_range(0, 6));
         tick = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 249) == 0) do_reset();
         else cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
